// File: rtl/data_memory_pkg.sv
// -----------------------------------------------------------------------------
// data_memory_pkg
// Shared types and default sizes for the single-port data memory.
//   state_e    : controller state (CLEAR sweep / IDLE accepting requests)
//   DM_DATA_W  : default word width in bits
//   DM_ADDR_W  : default address width in bits
// -----------------------------------------------------------------------------
package data_memory_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_e;

    localparam int DM_DATA_W = 8;
    localparam int DM_ADDR_W = 5;

endpackage : data_memory_pkg

// File: rtl/data_memory_array.sv
// -----------------------------------------------------------------------------
// data_memory_array
// Plain DEPTH x DATA_W storage with one synchronous write port and one
// combinational read port. No reset: contents are owned by the controller.
//   clk    in   clock
//   we     in   write enable
//   waddr  in   write word address
//   wdata  in   write data
//   raddr  in   read word address
//   rdata  out  read data (combinational)
// -----------------------------------------------------------------------------
module data_memory_array #(
    parameter  int DATA_W = 8,
    parameter  int DEPTH  = 32,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: the storage array has no reset; clearing is done by the
    // controller's sweep so the array maps onto plain RAM cells.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Addresses >= DEPTH are masked by the controller before use.
    assign rdata = mem[raddr];

endmodule : data_memory_array

// File: rtl/data_memory_sp.sv
// -----------------------------------------------------------------------------
// data_memory_sp
// Parametrised single-port data memory with request/ready handshake, a
// hardware zeroing sweep (after reset or on Clear) and an optional
// registered read with a one-cycle valid strobe.
//   Clk       in   clock, rising edge
//   Rst       in   synchronous active-high reset
//   Clear     in   start / restart a zeroing sweep
//   Req       in   access request, accepted only while Ready=1
//   We        in   1 = write, 0 = read (with Req)
//   Address   in   word address
//   Data_in   in   write data
//   Ready     out  1 = idle and accepting requests
//   Data_out  out  read data
//   Rd_valid  out  Data_out holds the result of an accepted read
// -----------------------------------------------------------------------------
module data_memory_sp
    import data_memory_pkg::*;
#(
    parameter int DATA_W   = DM_DATA_W,
    parameter int ADDR_W   = DM_ADDR_W,
    parameter int DEPTH    = 32,
    parameter int READ_REG = 1
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Clear,
    input  logic              Req,
    input  logic              We,
    input  logic [ADDR_W-1:0] Address,
    input  logic [DATA_W-1:0] Data_in,
    output logic              Ready,
    output logic [DATA_W-1:0] Data_out,
    output logic              Rd_valid
);

    localparam int                PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_A  = (ADDR_W + 1)'(DEPTH);

    state_e            state_q,   state_d;
    logic [PTR_W-1:0]  clr_ptr_q, clr_ptr_d;

    logic              in_range;
    logic              rd_req;
    logic              wr_req;
    logic              mem_we;
    logic [PTR_W-1:0]  mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] rd_data;

    // Extra leading zero lets non-power-of-two depths compare cleanly.
    assign in_range = ({1'b0, Address} < DEPTH_A);

    // Ready follows the state but drops immediately while Rst is held.
    assign Ready  = (state_q == IDLE) && !Rst;
    assign rd_req = Req && !We && Ready;
    assign wr_req = Req &&  We && Ready && in_range;

    // ---------------------------------------------------------------- state
    // NOTE: sequential state is updated with non-blocking assignments so all
    // flops sample the same pre-edge values.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q   <= CLEAR;
            clr_ptr_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end

    // ----------------------------------------------------------- next state
    // NOTE: every signal written here gets a default first so no latch is
    // inferred on paths that leave it untouched.
    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        unique case (state_q)
            CLEAR: begin
                if (Clear) begin
                    clr_ptr_d = '0;
                end else if (clr_ptr_q == LAST_PTR) begin
                    state_d = IDLE;   // pointer parks at DEPTH-1, no wrap
                end else begin
                    clr_ptr_d = clr_ptr_q + PTR_W'(1);
                end
            end
            IDLE: begin
                // A write sampled with Clear still lands; the sweep zeroes it.
                if (Clear) begin
                    state_d   = CLEAR;
                    clr_ptr_d = '0;
                end
            end
            default: begin
                state_d   = CLEAR;
                clr_ptr_d = '0;
            end
        endcase
    end

    // ------------------------------------------------ write-port mux (output)
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = Address[PTR_W-1:0];
        mem_wdata = Data_in;
        if (!Rst) begin
            if (state_q == CLEAR) begin
                mem_we    = 1'b1;
                mem_addr  = clr_ptr_q;
                mem_wdata = '0;
            end else if (wr_req) begin
                mem_we = 1'b1;
            end
        end
    end

    data_memory_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk   (Clk),
        .we    (mem_we),
        .waddr (mem_addr),
        .wdata (mem_wdata),
        .raddr (Address[PTR_W-1:0]),
        .rdata (mem_rdata)
    );

    // Out-of-range reads return zero instead of aliasing a stored word.
    assign rd_data = in_range ? mem_rdata : '0;

    // ------------------------------------------------------------ read path
    generate
        if (READ_REG != 0) begin : g_read_reg
            logic [DATA_W-1:0] dout_q, dout_d;
            logic              rd_valid_q, rd_valid_d;

            // Data_out holds between reads; only Rst clears it.
            always_comb begin
                dout_d     = dout_q;
                rd_valid_d = rd_req;
                if (rd_req) begin
                    dout_d = rd_data;
                end
            end

            always_ff @(posedge Clk) begin
                if (Rst) begin
                    dout_q     <= '0;
                    rd_valid_q <= 1'b0;
                end else begin
                    dout_q     <= dout_d;
                    rd_valid_q <= rd_valid_d;
                end
            end

            assign Data_out = dout_q;
            assign Rd_valid = rd_valid_q;
        end else begin : g_read_comb
            assign Data_out = rd_data;
            assign Rd_valid = rd_req;
        end
    endgenerate

endmodule : data_memory_sp

// File: tb/tb_data_memory_sp.sv
// -----------------------------------------------------------------------------
// tb_data_memory_sp
// Drives two instances (DEPTH=32 and DEPTH=20, both registered read) with
// the same stimulus. A behavioural model per instance tracks memory contents,
// the number of edges left before Ready and the expected read result.
// -----------------------------------------------------------------------------
module tb_data_memory_sp;

    localparam int NDUT = 2;
    localparam int DEP [NDUT] = '{32, 20};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clear = 1'b0;
    logic       req = 1'b0;
    logic       we = 1'b0;
    logic [4:0] addr = '0;
    logic [7:0] din = '0;

    logic       ready [NDUT];
    logic [7:0] dout  [NDUT];
    logic       valid [NDUT];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    data_memory_sp #(.DATA_W(8), .ADDR_W(5), .DEPTH(32), .READ_REG(1)) dut_d32 (
        .Clk(clk), .Rst(rst), .Clear(clear), .Req(req), .We(we),
        .Address(addr), .Data_in(din),
        .Ready(ready[0]), .Data_out(dout[0]), .Rd_valid(valid[0])
    );

    data_memory_sp #(.DATA_W(8), .ADDR_W(5), .DEPTH(20), .READ_REG(1)) dut_d20 (
        .Clk(clk), .Rst(rst), .Clear(clear), .Req(req), .We(we),
        .Address(addr), .Data_in(din),
        .Ready(ready[1]), .Data_out(dout[1]), .Rd_valid(valid[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------ behavioural model
    int         mdl_left  [NDUT];          // edges until Ready
    logic [7:0] mdl_mem   [NDUT][32];
    logic       mdl_valid [NDUT];
    logic [7:0] mdl_dout  [NDUT];
    bit         mdl_live = 0;

    task automatic mdl_zero(input int k);
        for (int a = 0; a < 32; a++) mdl_mem[k][a] = 8'h00;
    endtask

    task automatic mdl_edge(input int k);
        int d;
        d = DEP[k];
        if (rst) begin
            mdl_left[k]  = d;
            mdl_valid[k] = 1'b0;
            mdl_dout[k]  = 8'h00;
            mdl_zero(k);
        end else if (mdl_left[k] != 0) begin
            mdl_valid[k] = 1'b0;
            if (clear) mdl_left[k] = d;
            else       mdl_left[k] = mdl_left[k] - 1;
        end else begin
            mdl_valid[k] = 1'b0;
            if (req && we && int'(addr) < d) mdl_mem[k][addr] = din;
            if (req && !we) begin
                mdl_valid[k] = 1'b1;
                mdl_dout[k]  = (int'(addr) < d) ? mdl_mem[k][addr] : 8'h00;
            end
            if (clear) begin
                mdl_left[k] = d;
                mdl_zero(k);
            end
        end
    endtask

    always @(posedge clk) begin
        for (int k = 0; k < NDUT; k++) mdl_edge(k);
        if (rst) mdl_live = 1;
    end

    // Compare process: outputs sampled mid-cycle, inputs change just after posedge.
    always @(negedge clk) begin
        if (mdl_live) begin
            for (int k = 0; k < NDUT; k++) begin
                check($sformatf("ready[%0d]", k),    32'(ready[k]), 32'((mdl_left[k] == 0) && !rst));
                check($sformatf("rd_valid[%0d]", k), 32'(valid[k]), 32'(mdl_valid[k]));
                check($sformatf("data_out[%0d]", k), 32'(dout[k]),  32'(mdl_dout[k]));
            end
        end
    end

    // ------------------------------------------------------------- stimulus
    task automatic drive(input logic r, input logic c, input logic q, input logic w,
                         input logic [4:0] a, input logic [7:0] d);
        @(posedge clk);
        #1;
        rst = r; clear = c; req = q; we = w; addr = a; din = d;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 8'h00);
    endtask

    task automatic wr(input logic [4:0] a, input logic [7:0] d);
        drive(1'b0, 1'b0, 1'b1, 1'b1, a, d);
    endtask

    task automatic rd(input logic [4:0] a);
        drive(1'b0, 1'b0, 1'b1, 1'b0, a, 8'h00);
    endtask

    // Counts edges after the last reset edge until each instance is ready.
    task automatic count_ready(input string tag);
        int r0, r1;
        r0 = -1;
        r1 = -1;
        for (int i = 1; i <= 100; i++) begin
            idle();
            if (ready[0] && r0 < 0) r0 = i;
            if (ready[1] && r1 < 0) r1 = i;
            if (ready[0] && ready[1]) break;
        end
        check({tag, "_edges_d32"}, 32'(r0), 32'd32);
        check({tag, "_edges_d20"}, 32'(r1), 32'd20);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int low_cnt;

        // 1: reset for two cycles, sweep length, all words read as zero.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 8'h00);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 8'h00);
        idle();
        check("t1_ready_in_reset", 32'(ready[0]), 32'd0);
        count_ready("t1");
        for (int a = 0; a < 32; a++) rd(5'(a));
        idle();
        check("t1_last_read", 32'(dout[0]), 32'h00);

        // 2: single write then read, one-cycle latency.
        wr(5'd3, 8'hA5);
        rd(5'd3);
        idle();
        check("t2_valid", 32'(valid[0]), 32'd1);
        check("t2_dout",  32'(dout[0]),  32'hA5);
        idle();
        check("t2_valid_drop", 32'(valid[0]), 32'd0);
        check("t2_dout_hold",  32'(dout[0]),  32'hA5);

        // 3: back-to-back reads 3, 4, 3.
        wr(5'd4, 8'h5A);
        rd(5'd3);
        rd(5'd4);
        check("t3_v0", 32'(valid[0]), 32'd1);
        check("t3_d0", 32'(dout[0]),  32'hA5);
        rd(5'd3);
        check("t3_v1", 32'(valid[0]), 32'd1);
        check("t3_d1", 32'(dout[0]),  32'h5A);
        idle();
        check("t3_v2", 32'(valid[0]), 32'd1);
        check("t3_d2", 32'(dout[0]),  32'hA5);
        idle();
        check("t3_v3", 32'(valid[0]), 32'd0);

        // 4: clear while idle, restart 10 edges into the sweep, writes ignored.
        low_cnt = 0;
        drive(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 8'h00);
        for (int i = 0; i < 9; i++) begin
            wr(5'(i), 8'hFF);
            if (!ready[0]) low_cnt++;
        end
        drive(1'b0, 1'b1, 1'b1, 1'b1, 5'd3, 8'hFF);
        if (!ready[0]) low_cnt++;
        for (int i = 0; i < 100; i++) begin
            idle();
            if (ready[0]) break;
            low_cnt++;
        end
        check("t4_low_cycles", 32'(low_cnt), 32'd42);
        rd(5'd3);
        idle();
        check("t4_rd3_valid", 32'(valid[0]), 32'd1);
        check("t4_rd3_zero",  32'(dout[0]),  32'h00);

        // 5: out-of-range access on the DEPTH=20 instance.
        wr(5'd25, 8'hFF);
        wr(5'd5,  8'h77);
        rd(5'd25);
        rd(5'd5);
        check("t5_d20_oor_valid", 32'(valid[1]), 32'd1);
        check("t5_d20_oor_zero",  32'(dout[1]),  32'h00);
        check("t5_d32_inrange",   32'(dout[0]),  32'hFF);
        idle();
        check("t5_d20_addr5", 32'(dout[1]), 32'h77);

        // Randomised traffic with occasional clear and rare reset.
        for (int i = 0; i < 3000; i++) begin
            drive(1'($urandom_range(0, 499) == 0),
                  1'($urandom_range(0, 79) == 0),
                  1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 31)),
                  8'($urandom));
        end
        idle();
        for (int i = 0; i < 40; i++) idle();

        // 6: reset on the cycle after a read request drops the read.
        wr(5'd3, 8'hC3);
        rd(5'd3);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 8'h00);
        idle();
        check("t6_valid_dropped", 32'(valid[0]), 32'd0);
        check("t6_dout_reset",    32'(dout[0]),  32'h00);
        count_ready("t6");
        rd(5'd3);
        idle();
        check("t6_swept", 32'(dout[0]), 32'h00);

        idle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_data_memory_sp
